sram_read_arbiter: RTL
======================

Name: sram_read_arbiter

Overview:
- Shares the read ports of the 16-bank SRAM cluster among NUM_REQ pipeline requesters.
- Each requester addresses one bank by sram_id; the block runs an independent round-robin arbiter per bank.
- It drives each bank's r_en/r_addr and routes the 1-cycle-latency read data back to the granted requester through a registered response stage.
- It sits between the match/action stage request logic and the SRAM cluster instances.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, ≥2)
- NUM_SRAM, 16, number of SRAM banks
- ADDR_W, 8, bank address width
- DATA_W, 64, bank read data width
- ID_W, 4, sram_id width, log2(NUM_SRAM)

Ports:
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  grant this cycle (combinational)
- req_sram_id  in  NUM_REQ*ID_W  target bank per requester
- req_addr  in  NUM_REQ*ADDR_W  bank address per requester
- rsp_valid  out  NUM_REQ  read data valid per requester
- rsp_data  out  NUM_REQ*DATA_W  read data per requester
- sram_r_en  out  NUM_SRAM  per-bank read enable
- sram_r_addr  out  NUM_SRAM*ADDR_W  per-bank read address
- sram_r_data  in  NUM_SRAM*DATA_W  per-bank read data, valid the cycle after r_en

Behaviour:
- Handshake: a request transfers when req_valid[i] & req_ready[i]. The requester holds valid, sram_id and addr stable until ready. There is no response backpressure; rsp_valid is a 1-cycle pulse the requester must consume.
- Arbitration, per bank s, each cycle:
  - Candidates are requesters with valid and sram_id==s.
  - Priority starts at rr_ptr[s] and wraps ascending.
  - At most one grant per bank per cycle. Requesters on different banks are granted in the same cycle.
- rr_ptr[s] update: on a grant to requester g, rr_ptr[s] <= (g+1) mod NUM_REQ. With no grant, rr_ptr[s] holds. Reset value is 0.
- Bank drive, combinational in grant cycle T: sram_r_en[s] = 1 iff bank s granted, and sram_r_addr[s] = the granted requester's addr. Otherwise en = 0 and addr = 0.
- Tracking: stage-1 registers per requester, inflight_v[i] and inflight_id[i], are captured at T.
- Response: at T+1 the block selects sram_r_data[inflight_id[i]] into the rsp_data[i] register. rsp_valid[i] = 1 at T+2. Fixed accept-to-response latency is 2 cycles.
- Throughput: each requester can issue every cycle when uncontended; responses stay in order per requester.
- rsp_data holds its last value when rsp_valid = 0 (no clear).
- sram_id ≥ NUM_SRAM: the request is never granted (ready stays 0). This is unreachable at default parameters.
- Fairness: with k contenders on a bank, each is granted within k cycles.
- Reset asserted mid-operation, all asynchronously:
  - rr_ptr cleared to 0; inflight_v and rsp_valid cleared; rsp_data cleared to 0.
  - In-flight reads are dropped.
  - Combinational outputs follow inputs with the cleared state.
- Reset values: req_ready follows arbitration (0 when no valid); rsp_valid = 0; rsp_data = 0; sram_r_en = 0; sram_r_addr = 0.

Decomposition:
- Package sram_cluster_pkg holds NUM_SRAM, ADDR_W, DATA_W and ID_W constants, plus typedefs sram_addr_t, sram_data_t and sram_id_t shared with the SRAM cluster.
- Sub-module rr_arbiter (NUM_REQ request vector in, one-hot grant out, internal pointer with async active-low reset), instantiated once per bank.
- The top level holds the request decode, the bank muxes and the response pipeline.

Test Plan:
- Single request: requester 0, id=3, addr=0x12, bank 3 returns 0xDEAD_BEEF at T+1. Expect ready[0]=1 at T, sram_r_en[3]=1, sram_r_addr[3]=0x12 at T, then rsp_valid[0]=1 and rsp_data[0]=0xDEAD_BEEF at T+2, with other rsp_valid low.
- Parallel banks: requesters 0-3 target ids 0,1,2,3 simultaneously. Expect all four ready in the same cycle and all four responses at T+2 with their own bank data.
- Contention: all four requesters hold valid to id=5 for 8 cycles. Expect grant order 0,1,2,3,0,1,2,3, one sram_r_en[5] per cycle, and each requester receiving 2 responses.
- Pointer retention: requester 2 granted on bank 7, bank idle 5 cycles, then requesters 0 and 3 request bank 7. Expect 3 granted first, then 0.
- Back-to-back streaming: requester 1 issues addrs 0,1,2,3 on id=9 on consecutive cycles, bank returns data=addr+0x100. Expect rsp_valid[1] high 4 consecutive cycles with 0x100..0x103 in order.
- Reset mid-flight: grant at T, reset low at T+1 for 1 cycle. Expect rsp_valid=0 and rsp_data=0 immediately, no response at T+2, and rr_ptr back to 0 (requester 0 wins the next tie).

Source files
------------

// File: rtl/sram_cluster_pkg.sv
// Shared constants and types for the 16-bank SRAM cluster and the logic
// that drives its read ports.
package sram_cluster_pkg;

    localparam int NUM_SRAM = 16;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 64;
    localparam int ID_W     = $clog2(NUM_SRAM);

    typedef logic [ADDR_W-1:0] sram_addr_t;
    typedef logic [DATA_W-1:0] sram_data_t;
    typedef logic [ID_W-1:0]   sram_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from rr_ptr with
// wrap-around; the pointer moves to one past the winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] gidx;
    logic             found;

    // NUM_REQ is a power of two, so the pointer sum wraps on its own.
    always_comb begin
        grant = '0;
        found = 1'b0;
        gidx  = rr_ptr;
        idx   = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + PTR_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (found) grant[gidx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= gidx + PTR_W'(1);
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Shares the SRAM cluster read ports among NUM_REQ requesters: per-bank
// round-robin grant, combinational bank drive, 2-cycle registered response.
module sram_read_arbiter
    import sram_cluster_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int NUM_SRAM = sram_cluster_pkg::NUM_SRAM,
    parameter int ADDR_W   = sram_cluster_pkg::ADDR_W,
    parameter int DATA_W   = sram_cluster_pkg::DATA_W,
    parameter int ID_W     = sram_cluster_pkg::ID_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*ID_W-1:0]    req_sram_id,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0]  rsp_data,
    output logic [NUM_SRAM-1:0]        sram_r_en,
    output logic [NUM_SRAM*ADDR_W-1:0] sram_r_addr,
    input  logic [NUM_SRAM*DATA_W-1:0] sram_r_data
);

    logic [ADDR_W-1:0]  addr_arr   [NUM_REQ];
    logic [ID_W-1:0]    id_arr     [NUM_REQ];
    logic [DATA_W-1:0]  bank_rdata [NUM_SRAM];
    logic [NUM_REQ-1:0] bank_req   [NUM_SRAM];
    logic [NUM_REQ-1:0] bank_grant [NUM_SRAM];

    logic [NUM_REQ-1:0] inflight_v_p1;
    logic [ID_W-1:0]    inflight_id_p1 [NUM_REQ];
    logic [DATA_W-1:0]  sel_data_p1    [NUM_REQ];
    logic [NUM_REQ-1:0] rsp_valid_p2;
    logic [DATA_W-1:0]  rsp_data_p2    [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign id_arr[i]   = req_sram_id[i*ID_W +: ID_W];
        assign rsp_data[i*DATA_W +: DATA_W] = rsp_data_p2[i];
    end

    for (genvar s = 0; s < NUM_SRAM; s++) begin : g_bank
        assign bank_rdata[s] = sram_r_data[s*DATA_W +: DATA_W];
        rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
            .clock (clock),
            .reset (reset),
            .req   (bank_req[s]),
            .grant (bank_grant[s])
        );
    end

    // Ids at or above NUM_SRAM match no bank and so are never granted.
    always_comb begin
        for (int s = 0; s < NUM_SRAM; s++)
            for (int i = 0; i < NUM_REQ; i++)
                bank_req[s][i] = req_valid[i] && (id_arr[i] == ID_W'(s));
    end

    always_comb begin
        req_ready   = '0;
        sram_r_en   = '0;
        sram_r_addr = '0;
        for (int s = 0; s < NUM_SRAM; s++) begin
            sram_r_en[s] = |bank_grant[s];
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bank_grant[s][i]) begin
                    req_ready[i] = 1'b1;
                    sram_r_addr[s*ADDR_W +: ADDR_W] = addr_arr[i];
                end
            end
        end
    end

    // Stage p1: remember which bank each accepted read went to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            inflight_v_p1 <= '0;
        else
            inflight_v_p1 <= req_ready;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) inflight_id_p1[i] <= id_arr[i];
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_data_p1[i] = '0;
            for (int s = 0; s < NUM_SRAM; s++)
                if (inflight_id_p1[i] == ID_W'(s)) sel_data_p1[i] = bank_rdata[s];
        end
    end

    // Stage p2: capture bank data; rsp_data holds between responses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsp_valid_p2 <= '0;
            for (int i = 0; i < NUM_REQ; i++) rsp_data_p2[i] <= '0;
        end else begin
            rsp_valid_p2 <= inflight_v_p1;
            for (int i = 0; i < NUM_REQ; i++)
                if (inflight_v_p1[i]) rsp_data_p2[i] <= sel_data_p1[i];
        end
    end

    assign rsp_valid = rsp_valid_p2;

endmodule
